// File: rtl/lcd_hd44780_drv.sv
// HD44780 4-bit write-only driver: power-on init, then one DDRAM address-set
// command plus one data write per accepted character, timed by cycle counters.
module lcd_hd44780_drv #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_E       = 12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       lcd_row,
  input  logic [3:0] lcd_col,
  input  logic [7:0] lcd_char,
  input  logic       lcd_we,
  output logic       lcd_busy,
  output logic       overrun,
  output logic       init_done,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [3:0] LCD_DB
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX = max2(max2(max2(T_POWERUP, T_INIT1), max2(T_INIT2, T_CMD)),
                                       max2(max2(T_CLEAR, T_SETUP), T_E));
  localparam int unsigned CW = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT_NIB, INIT_BYTE, IDLE, ADDR, DATA} state_e;
  typedef enum logic [1:0] {PH_SETUP, PH_EHI, PH_ELO, PH_WAIT} phase_e;

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic            hi_q, hi_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            row_q, row_d;
  logic [3:0]      col_q, col_d;
  logic [7:0]      char_q, char_d;
  logic            overrun_q, overrun_d;
  logic            init_done_q, init_done_d;
  logic            busy_q, busy_d;
  logic            e_q, e_d;
  logic            rs_q, rs_d;
  logic [3:0]      db_q, db_d;

  logic [7:0]      cur_byte, nxt_byte;
  logic [CW-1:0]   wait_len, ph_len;
  logic            xfer_d;

  // Init single nibbles are returned duplicated so the hi/lo select is irrelevant.
  function automatic logic [7:0] byte_of(input state_e st, input logic [1:0] idx,
                                         input logic row, input logic [3:0] col,
                                         input logic [7:0] ch);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      INIT_NIB:  b = (idx == 2'd3) ? 8'h22 : 8'h33;
      INIT_BYTE: begin
        case (idx)
          2'd0:    b = 8'h28;
          2'd1:    b = 8'h0C;
          2'd2:    b = 8'h06;
          default: b = 8'h01;
        endcase
      end
      ADDR:      b = {1'b1, row, 2'b00, col};
      DATA:      b = ch;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    cur_byte = byte_of(state_q, idx_q, row_q, col_q, char_q);
    wait_len = CW'(T_CMD);
    if (state_q == INIT_NIB) begin
      case (idx_q)
        2'd0:    wait_len = CW'(T_INIT1);
        2'd1:    wait_len = CW'(T_INIT2);
        default: wait_len = CW'(T_CMD);
      endcase
    end else if (state_q != DATA && cur_byte == 8'h01) begin
      wait_len = CW'(T_CLEAR);
    end
    case (phase_q)
      PH_SETUP: ph_len = CW'(T_SETUP);
      PH_EHI:   ph_len = CW'(T_E);
      PH_ELO:   ph_len = CW'(T_E);
      default:  ph_len = wait_len;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q + CW'(1);
    row_d       = row_q;
    col_d       = col_q;
    char_d      = char_q;
    init_done_d = init_done_q;
    overrun_d   = overrun_q | (lcd_we & busy_q);

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == CW'(T_POWERUP)) begin
          state_d = INIT_NIB;
          phase_d = PH_SETUP;
          hi_d    = 1'b1;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (lcd_we && !busy_q) begin
          state_d = ADDR;
          phase_d = PH_SETUP;
          hi_d    = 1'b1;
          row_d   = lcd_row;
          col_d   = lcd_col;
          char_d  = lcd_char;
        end
      end
      default: begin
        if (cnt_q == ph_len - CW'(1)) begin
          cnt_d = '0;
          case (phase_q)
            PH_SETUP: phase_d = PH_EHI;
            PH_EHI:   phase_d = PH_ELO;
            PH_ELO: begin
              if (hi_q && state_q != INIT_NIB) begin
                hi_d    = 1'b0;
                phase_d = PH_SETUP;
              end else begin
                phase_d = PH_WAIT;
              end
            end
            default: begin
              phase_d = PH_SETUP;
              hi_d    = 1'b1;
              case (state_q)
                INIT_NIB: begin
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) state_d = INIT_BYTE;
                end
                INIT_BYTE: begin
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                  end
                end
                ADDR:    state_d = DATA;
                default: state_d = IDLE;
              endcase
            end
          endcase
        end
      end
    endcase

    // Bus outputs are derived from the next state so they can be registered.
    nxt_byte = byte_of(state_d, idx_d, row_d, col_d, char_d);
    xfer_d   = (state_d inside {INIT_NIB, INIT_BYTE, ADDR, DATA});
    e_d      = xfer_d && (phase_d == PH_EHI);
    rs_d     = (state_d == DATA);
    db_d     = xfer_d ? (hi_d ? nxt_byte[7:4] : nxt_byte[3:0]) : '0;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= PWR_WAIT;
      phase_q     <= PH_SETUP;
      hi_q        <= 1'b1;
      idx_q       <= '0;
      cnt_q       <= '0;
      row_q       <= 1'b0;
      col_q       <= '0;
      char_q      <= '0;
      overrun_q   <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      db_q        <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      char_q      <= char_d;
      overrun_q   <= overrun_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      db_q        <= db_d;
    end
  end

  assign lcd_busy  = busy_q;
  assign overrun   = overrun_q;
  assign init_done = init_done_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_E     = e_q;
  assign LCD_DB    = db_q;

endmodule

// File: tb/tb_lcd_hd44780_drv.sv
// Scoreboard bench for lcd_hd44780_drv: expected bus nibbles are queued by the
// stimulus thread and popped by a monitor on every E strobe.
module tb_lcd_hd44780_drv;

  localparam int unsigned T_POWERUP = 20;
  localparam int unsigned T_INIT1   = 10;
  localparam int unsigned T_INIT2   = 5;
  localparam int unsigned T_CMD     = 8;
  localparam int unsigned T_CLEAR   = 30;
  localparam int unsigned T_SETUP   = 2;
  localparam int unsigned T_E       = 3;
  localparam int N_N     = T_SETUP + 2 * T_E;
  localparam int N_B     = 2 * N_N + T_CMD;
  localparam int INIT_CY = T_POWERUP + 4 * N_N + T_INIT1 + T_INIT2 + 2 * T_CMD
                         + 4 * 2 * N_N + 3 * T_CMD + T_CLEAR;
  localparam int LIMIT   = 5000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       lcd_row = 1'b0;
  logic [3:0] lcd_col = '0;
  logic [7:0] lcd_char = '0;
  logic       lcd_we = 1'b0;
  logic       lcd_busy, overrun, init_done, LCD_RS, LCD_RW, LCD_E;
  logic [3:0] LCD_DB;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] exp_q[$];

  lcd_hd44780_drv #(
    .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
    .T_CLEAR(T_CLEAR), .T_SETUP(T_SETUP), .T_E(T_E)
  ) dut (
    .CLK(CLK), .RST(RST), .lcd_row(lcd_row), .lcd_col(lcd_col), .lcd_char(lcd_char),
    .lcd_we(lcd_we), .lcd_busy(lcd_busy), .overrun(overrun), .init_done(init_done),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_DB(LCD_DB)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: HD44780 command/data bytes expressed as {RS, nibble} strobes.
  task automatic push_byte(input bit rs, input int b);
    logic [7:0] v;
    v = 8'(b);
    exp_q.push_back({rs, v[7:4]});
    exp_q.push_back({rs, v[3:0]});
  endtask

  task automatic push_init();
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(1'b0, 'h28);
    push_byte(1'b0, 'h0C);
    push_byte(1'b0, 'h06);
    push_byte(1'b0, 'h01);
  endtask

  task automatic push_write(input int row, input int col, input int ch);
    push_byte(1'b0, 'h80 + row * 'h40 + col);
    push_byte(1'b1, ch);
  endtask

  // Monitor: pop one expected nibble per E rising, check pulse width and hold.
  bit         e_prev = 1'b0;
  int         hi_cnt = 0;
  logic [4:0] last_exp = '0;
  always @(negedge CLK) begin
    if (RST) begin
      e_prev = 1'b0;
      hi_cnt = 0;
    end else begin
      if (LCD_E && !e_prev) begin
        hi_cnt = 1;
        chk("rw_low", int'(LCD_RW), 0);
        if (exp_q.size() == 0) begin
          last_exp = 5'h1F;
          chk("unexpected_strobe", int'({LCD_RS, LCD_DB}), -1);
        end else begin
          last_exp = exp_q.pop_front();
          chk("strobe_rs_db", int'({LCD_RS, LCD_DB}), int'(last_exp));
        end
      end else if (LCD_E) begin
        hi_cnt++;
      end else if (e_prev) begin
        chk("e_high_width", hi_cnt, T_E);
        chk("hold_rs_db", int'({LCD_RS, LCD_DB}), int'(last_exp));
      end
      e_prev = LCD_E;
    end
  end

  // Counts busy-high samples (one per cycle); optionally pulses lcd_we at sample pulse_at.
  task automatic run_busy(input int pulse_at, output int n);
    n = 0;
    while (lcd_busy && n < LIMIT) begin
      n++;
      lcd_we = (n == pulse_at);
      if (lcd_we) begin
        lcd_row  = 1'($urandom_range(0, 1));
        lcd_col  = 4'($urandom_range(0, 15));
        lcd_char = 8'($urandom_range(0, 255));
      end
      @(posedge CLK); #1;
    end
    lcd_we = 1'b0;
  endtask

  task automatic start_write(input int row, input int col, input int ch);
    lcd_row  = 1'(row);
    lcd_col  = 4'(col);
    lcd_char = 8'(ch);
    lcd_we   = 1'b1;
    push_write(row, col, ch);
    @(posedge CLK); #1;
    lcd_we = 1'b0;
  endtask

  task automatic do_write(input int row, input int col, input int ch, input int pulse_at);
    int n;
    start_write(row, col, ch);
    run_busy(pulse_at, n);
    chk("write_busy_len", n, 2 * N_B);
  endtask

  task automatic reset_and_init(input int cycles, input int pulse_at, input bit check_vals);
    int n;
    RST = 1'b1;
    exp_q.delete();
    repeat (cycles) begin
      @(posedge CLK); #1;
    end
    if (check_vals) begin
      chk("rst_e", int'(LCD_E), 0);
      chk("rst_rs", int'(LCD_RS), 0);
      chk("rst_rw", int'(LCD_RW), 0);
      chk("rst_db", int'(LCD_DB), 0);
      chk("rst_busy", int'(lcd_busy), 1);
      chk("rst_init_done", int'(init_done), 0);
    end
    chk("rst_overrun", int'(overrun), 0);
    push_init();
    RST = 1'b0;
    @(posedge CLK); #1;
    run_busy(pulse_at, n);
    chk("init_busy_len", n, INIT_CY);
    chk("init_done_at_idle", int'(init_done), 1);
  endtask

  initial begin
    int k;
    reset_and_init(3, 0, 1'b1);
    chk("overrun_after_init", int'(overrun), 0);

    do_write(0, 5, 'h41, 0);
    do_write(1, 15, 'h7A, 0);

    do_write(0, 2, 'h5A, 10);
    chk("overrun_set_write", int'(overrun), 1);
    do_write(1, 0, 'h30, 0);
    chk("overrun_sticky", int'(overrun), 1);

    reset_and_init(2, 60, 1'b0);
    chk("overrun_set_init", int'(overrun), 1);
    reset_and_init(1, 0, 1'b0);
    chk("overrun_cleared", int'(overrun), 0);

    for (int i = 0; i < 32; i++) begin
      do_write(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 255)), 0);
    end
    chk("overrun_burst", int'(overrun), 0);

    start_write(1, 7, 'hA5);
    k = 0;
    while (!(LCD_E && LCD_RS) && k < 200) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("data_ehi_reached", int'(LCD_E && LCD_RS), 1);
    RST = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    chk("midrst_e", int'(LCD_E), 0);
    chk("midrst_busy", int'(lcd_busy), 1);
    chk("midrst_init_done", int'(init_done), 0);
    reset_and_init(1, 0, 1'b1);
    do_write(0, 15, 'h21, 0);

    repeat (5) @(posedge CLK);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_hd44780_drv.md
Name: lcd_hd44780_drv

Overview:
- Downstream consumer of the LCD write stream (lcd_row/lcd_col/lcd_char/lcd_we, returning lcd_busy).
- Drives an HD44780-compatible 16x2 character module over its 4-bit, write-only bus.
- Performs the power-on init sequence, then turns each accepted character write into a DDRAM address-set command followed by a data write, with all bus timing generated from clock-cycle counters.

Parameters:
- T_POWERUP, 750000, cycles to wait after reset before the first init nibble (15 ms at 50 MHz)
- T_INIT1, 205000, wait after init nibble 1 (4.1 ms)
- T_INIT2, 5000, wait after init nibble 2 (100 us)
- T_CMD, 2000, post-byte wait for normal commands and data (40 us)
- T_CLEAR, 82000, post-byte wait after the clear command 0x01 (1.64 ms)
- T_SETUP, 2, cycles RS/DB are held stable with E low before E rises
- T_E, 12, cycles E is high, and also the hold cycles after E falls

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- lcd_row  in  1  target row, 0 or 1
- lcd_col  in  4  target column, 0..15
- lcd_char  in  8  character code
- lcd_we  in  1  write request, one cycle per character
- lcd_busy  out  1  high = request not accepted this cycle
- overrun  out  1  sticky: lcd_we arrived while lcd_busy was high
- init_done  out  1  high once the init sequence has completed; stays high until RST
- LCD_RS  out  1  register select (0 = command, 1 = data)
- LCD_RW  out  1  constant 0
- LCD_E  out  1  enable strobe
- LCD_DB  out  4  data nibble, mapped to DB7..DB4

Behaviour:
- Reset: CLK and RST only; RST is synchronous and active-high, sampled on the CLK rising edge.
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DB=0, lcd_busy=1, overrun=0, init_done=0.
- RST asserted mid-operation: the next edge forces E low and restarts from PWR_WAIT. No partial transfer resumes.
- Nibble phase, which is the basic unit:
  - SETUP: T_SETUP cycles, RS/DB driven, E=0.
  - EHI: T_E cycles, E=1.
  - ELO: T_E cycles, E=0.
  - RS/DB stay constant through all three sub-phases.
  - Nibble length N_N = T_SETUP + 2*T_E.
- Byte: high nibble, then low nibble, then WAIT for T_CMD cycles (T_CLEAR if the byte is 0x01).
  - Byte length N_B = 2*N_N + T_CMD.
- States: PWR_WAIT -> INIT_NIB -> INIT_BYTE -> IDLE -> ADDR -> DATA -> IDLE.
- PWR_WAIT: T_POWERUP cycles.
- INIT_NIB: four single nibbles with RS=0:
  - 0x3, then wait T_INIT1
  - 0x3, then wait T_INIT2
  - 0x3, then wait T_CMD
  - 0x2, then wait T_CMD
- INIT_BYTE: bytes with RS=0, in order:
  - 0x28 (4-bit, 2-line)
  - 0x0C (display on, cursor off)
  - 0x06 (increment, no shift)
  - 0x01 (clear, waits T_CLEAR)
  - Afterwards, init_done=1 and go to IDLE.
- IDLE: lcd_busy=0. All other states drive lcd_busy=1, registered.
- Accept: lcd_we & ~lcd_busy at an edge.
  - row/col/char are captured on that edge.
  - lcd_busy=1 from the next cycle.
- ADDR: byte {1'b1, lcd_row, 2'b00, lcd_col} with RS=0. Row 0 gives 0x80+col; row 1 gives 0xC0+col.
- DATA: captured char with RS=1, then return to IDLE.
- Write latency: lcd_busy is high for exactly 2*N_B cycles after the accept edge, then low.
- Back-to-back writes: a write may be accepted on the first cycle lcd_busy is low.
- lcd_we while lcd_busy=1, including during init: the request is dropped, overrun is set, and there is no other effect. overrun clears only on RST.
- No address auto-increment tracking: every write sets its address explicitly. Column 15 to 0 wrap is the upstream block's responsibility.

Test Plan (T_POWERUP=20, T_INIT1=10, T_INIT2=5, T_CMD=8, T_CLEAR=30, T_SETUP=2, T_E=3; so N_N=8, N_B=24):
- Init timing:
  - Stimulus: RST high 3 cycles, then low.
  - Required: E pulses nibbles 3,3,3,2 then bytes 28,0C,06,01 (high nibble first), each E high exactly 3 cycles with RS=0.
  - Required: lcd_busy first low 201 cycles after the first edge with RST=0, with init_done=1 on that same cycle.
- Row 0 write:
  - Stimulus: one-cycle lcd_we with row=0, col=5, char=0x41 in IDLE.
  - Required: DB nibbles 8,5 with RS=0, then 4,1 with RS=1.
  - Required: lcd_busy high exactly 48 cycles.
- Row 1 address:
  - Stimulus: row=1, col=15, char=0x7A.
  - Required: address byte 0xCF, data byte 0x7A.
- Overrun:
  - Stimulus: lcd_we pulsed during a write and again during init.
  - Required: both are dropped (no extra E pulses) and overrun=1 sticky.
  - Required: a later RST clears overrun to 0.
- Back-to-back:
  - Stimulus: a 32-character burst, each lcd_we issued on the first cycle lcd_busy is low.
  - Required: 32 address/data pairs in order, overrun stays 0.
- Mid-operation reset:
  - Stimulus: RST asserted during EHI of a data nibble.
  - Required: LCD_E=0 on the next edge, lcd_busy=1, init_done=0; full init sequence re-runs.
